// File: rtl/case_8_mul_arb_pkg.sv
// Shared widths, operand/product types and tag-width helper for the
// case_8 shared-multiplier arbiter.
package case_8_mul_arb_pkg;

    localparam int A_W   = 11;
    localparam int B_W   = 7;
    localparam int P_W   = 16;
    localparam int CNT_W = 16;

    typedef logic signed [A_W-1:0] opa_t;
    typedef logic signed [B_W-1:0] opb_t;
    typedef logic signed [P_W-1:0] prod_t;

    // Requester tag width; a single requester still needs one tag bit.
    function automatic int id_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/case_8_mul_arb_if.sv
// Request/response bundle between the case_8 loop bodies (master side)
// and the shared-multiplier arbiter (slave side).
interface case_8_mul_arb_if
    import case_8_mul_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = id_w(N_REQ)
);

    logic [N_REQ-1:0]     req_valid;
    logic [N_REQ*A_W-1:0] req_a;
    logic [N_REQ*B_W-1:0] req_b;
    logic [N_REQ-1:0]     req_ready;
    logic                 rsp_valid;
    logic [ID_W-1:0]      rsp_id;
    logic [P_W-1:0]       rsp_data;
    logic                 rsp_ready;
    logic [CNT_W-1:0]     busy_cnt;

    modport master (
        output req_valid,
        output req_a,
        output req_b,
        output rsp_ready,
        input  req_ready,
        input  rsp_valid,
        input  rsp_id,
        input  rsp_data,
        input  busy_cnt
    );

    modport slave (
        input  req_valid,
        input  req_a,
        input  req_b,
        input  rsp_ready,
        output req_ready,
        output rsp_valid,
        output rsp_id,
        output rsp_data,
        output busy_cnt
    );

endinterface

// File: rtl/case_8_mul_arb_rr.sv
// Combinational round-robin picker: first asserted request at or after
// rr_ptr, wrapping modulo N_REQ.
module case_8_mul_arb_rr
    import case_8_mul_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = id_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  rr_ptr,
    output logic             gnt_vld,
    output logic [ID_W-1:0]  gnt_idx
);

    localparam logic [ID_W:0] N_EXT = (ID_W+1)'(N_REQ);

    logic [ID_W:0]   w_sum;
    logic [ID_W-1:0] w_idx;

    // Scan farthest-from-pointer first so the nearest hit is the last written.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        w_sum   = '0;
        w_idx   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_sum   = {1'b0, rr_ptr} + (ID_W+1)'(k);
            w_sum   = (w_sum >= N_EXT) ? (w_sum - N_EXT) : w_sum;
            w_idx   = w_sum[ID_W-1:0];
            gnt_idx = req[w_idx] ? w_idx : gnt_idx;
            gnt_vld = gnt_vld | req[w_idx];
        end
    end

endmodule

// File: rtl/case_8_mul_arb.sv
// Round-robin arbiter sharing one signed A_W x B_W multiplier among N_REQ
// requesters; one registered, id-tagged response slot.
module case_8_mul_arb #(
    parameter int N_REQ = 4,
    parameter int ID_W  = case_8_mul_arb_pkg::id_w(N_REQ),
    parameter int A_W   = case_8_mul_arb_pkg::A_W,
    parameter int B_W   = case_8_mul_arb_pkg::B_W,
    parameter int P_W   = case_8_mul_arb_pkg::P_W
) (
    input  logic            ap_clk,
    input  logic            ap_rst_n,
    case_8_mul_arb_if.slave bus
);

    localparam int          M_W     = A_W + B_W;
    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    logic [ID_W-1:0]       r_rr_ptr;
    logic                  r_rsp_valid;
    logic [ID_W-1:0]       r_rsp_id;
    logic [P_W-1:0]        r_rsp_data;
    logic [15:0]           r_busy_cnt;

    logic                  w_slot_free;
    logic                  w_gnt_vld;
    logic                  w_xfer;
    logic [ID_W-1:0]       w_gnt_idx;
    logic [ID_W-1:0]       w_next_ptr;
    logic [N_REQ-1:0]      w_req_ready;
    logic signed [A_W-1:0] w_a_arr [N_REQ];
    logic signed [B_W-1:0] w_b_arr [N_REQ];
    logic signed [A_W-1:0] w_a;
    logic signed [B_W-1:0] w_b;
    logic signed [M_W-1:0] w_full;
    logic [P_W-1:0]        w_prod;

    // A held response blocks every requester until it is consumed.
    assign w_slot_free = !r_rsp_valid || bus.rsp_ready;
    assign w_xfer      = w_slot_free && w_gnt_vld;

    case_8_mul_arb_rr #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr (
        .req     (bus.req_valid),
        .rr_ptr  (r_rr_ptr),
        .gnt_vld (w_gnt_vld),
        .gnt_idx (w_gnt_idx)
    );

    genvar g;
    generate
        for (g = 0; g < N_REQ; g++) begin : g_unpack
            assign w_a_arr[g] = bus.req_a[g*A_W +: A_W];
            assign w_b_arr[g] = bus.req_b[g*B_W +: B_W];
        end
    endgenerate

    assign w_a = w_a_arr[w_gnt_idx];
    assign w_b = w_b_arr[w_gnt_idx];

    // Single shared multiplier; the low P_W bits wrap with no saturation.
    assign w_full = M_W'(w_a) * M_W'(w_b);
    assign w_prod = w_full[P_W-1:0];

    // One-hot accept for the granted requester, silenced while in reset.
    always_comb begin
        w_req_ready = '0;
        if (ap_rst_n && w_xfer) begin
            w_req_ready[w_gnt_idx] = 1'b1;
        end else begin
            w_req_ready = '0;
        end
    end

    // Priority moves to the requester just after the one served.
    always_comb begin
        w_next_ptr = '0;
        if (w_gnt_idx == ID_W'(N_REQ - 1)) begin
            w_next_ptr = '0;
        end else begin
            w_next_ptr = w_gnt_idx + ID_W'(1);
        end
    end

    // Response slot, round-robin pointer and saturating accept counter.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_data  <= '0;
            r_rr_ptr    <= '0;
            r_busy_cnt  <= 16'd0;
        end else if (w_xfer) begin
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= w_gnt_idx;
            r_rsp_data  <= w_prod;
            r_rr_ptr    <= w_next_ptr;
            if (r_busy_cnt != CNT_MAX) begin
                r_busy_cnt <= r_busy_cnt + 16'd1;
            end else begin
                r_busy_cnt <= r_busy_cnt;
            end
        end else if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end else begin
            r_rsp_valid <= r_rsp_valid;
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_id    = r_rsp_id;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.busy_cnt  = r_busy_cnt;

endmodule

// File: tb/tb_case_8_mul_arb.sv
// Scoreboard bench for case_8_mul_arb: per-requester operand queues feed a
// hold-until-accepted driver; a monitor pops expected responses on consumption.
module tb_case_8_mul_arb;
    import case_8_mul_arb_pkg::*;

    localparam int N = 4;

    typedef struct packed {
        logic [1:0]  id;
        logic [15:0] data;
    } exp_t;

    logic ap_clk = 1'b0;
    logic ap_rst_n;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];
    opa_t qa[N][$];
    opb_t qb[N][$];

    case_8_mul_arb_if #(.N_REQ(N)) bus ();

    case_8_mul_arb #(.N_REQ(N)) dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .bus      (bus)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_req(input int id, input int a, input int b, input logic [15:0] p);
        exp_t e;
        qa[id].push_back(11'(a));
        qb[id].push_back(7'(b));
        e.id   = 2'(id);
        e.data = p;
        sb.push_back(e);
    endtask

    task automatic wait_drain(input int max_cyc, input string name);
        int n = 0;
        while (sb.size() != 0 && n < max_cyc) begin
            @(negedge ap_clk);
            #1;
            n++;
        end
        check(name, 32'(sb.size()), 32'd0);
    endtask

    // Requester driver: hold each operand pair until it is accepted.
    initial begin
        logic [3:0]  cap;
        logic [3:0]  tv;
        logic [43:0] ta;
        logic [27:0] tb;
        bus.req_valid = 4'b0000;
        bus.req_a     = 44'd0;
        bus.req_b     = 28'd0;
        forever begin
            @(negedge ap_clk);
            cap = bus.req_valid & bus.req_ready;
            @(posedge ap_clk);
            #1;
            tv = 4'b0000;
            ta = 44'd0;
            tb = 28'd0;
            for (int i = 0; i < N; i++) begin
                if (cap[i] && qa[i].size() > 0) begin
                    qa[i].delete(0);
                    qb[i].delete(0);
                end
                if (qa[i].size() > 0) begin
                    tv[i]         = 1'b1;
                    ta[i*11 +: 11] = qa[i][0];
                    tb[i*7 +: 7]   = qb[i][0];
                end
            end
            bus.req_valid = tv;
            bus.req_a     = ta;
            bus.req_b     = tb;
        end
    end

    // Monitor: every consumed response is checked against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge ap_clk);
            if (ap_rst_n && bus.rsp_valid && bus.rsp_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_rsp: got id %0d data %0h, expected none", bus.rsp_id, bus.rsp_data);
                end else begin
                    e = sb.pop_front();
                    check("rsp_id", 32'(bus.rsp_id), 32'(e.id));
                    check("rsp_data", 32'(bus.rsp_data), 32'(e.data));
                end
            end
        end
    end

    int          t_id [11] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 2, 3};
    int          t_a  [11] = '{3, -5, 10, -7, 100, -1, 512, -1024, 0, 1000, -999};
    int          t_b  [11] = '{4, 6, -10, -8, 50, -1, 2, 1, -64, -64, 63};
    logic [15:0] t_p  [11] = '{16'h000C, 16'hFFE2, 16'hFF9C, 16'h0038, 16'h1388, 16'h0001,
                               16'h0400, 16'hFC00, 16'h0000, 16'h0600, 16'h0A27};

    // Directed stimulus sequence.
    initial begin
        ap_rst_n      = 1'b0;
        bus.rsp_ready = 1'b1;
        repeat (2) @(negedge ap_clk);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
        check("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
        check("rst_busy_cnt", 32'(bus.busy_cnt), 32'd0);

        // Single request, pending while still in reset.
        push_req(0, 5, -3, 16'hFFF1);
        @(posedge ap_clk);
        #2;
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
        check("single_req_ready", 32'(bus.req_ready), 32'h1);
        @(negedge ap_clk);
        check("single_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("single_busy_cnt", 32'(bus.busy_cnt), 32'd1);
        wait_drain(10, "single_drain");

        // Truncation wrap.
        @(negedge ap_clk);
        push_req(2, 1023, 63, 16'hFBC1);
        push_req(3, -1024, -64, 16'h0000);
        wait_drain(20, "wrap_drain");
        check("wrap_busy_cnt", 32'(bus.busy_cnt), 32'd3);

        // Backpressure: first response held for three cycles.
        @(posedge ap_clk);
        #1;
        bus.rsp_ready = 1'b0;
        @(negedge ap_clk);
        push_req(0, 7, 3, 16'h0015);
        push_req(1, -2, 5, 16'hFFF6);
        push_req(2, 100, -7, 16'hFD44);
        push_req(1, -300, -50, 16'h3A98);
        @(negedge ap_clk);
        check("bp_first_ready", 32'(bus.req_ready), 32'h1);
        repeat (3) begin
            @(negedge ap_clk);
            check("bp_hold_ready", 32'(bus.req_ready), 32'h0);
            check("bp_hold_valid", 32'(bus.rsp_valid), 32'd1);
            check("bp_hold_id", 32'(bus.rsp_id), 32'd0);
            check("bp_hold_data", 32'(bus.rsp_data), 32'h0015);
        end
        @(posedge ap_clk);
        #1;
        bus.rsp_ready = 1'b1;
        @(negedge ap_clk);
        check("bp_release_ready", 32'(bus.req_ready), 32'h2);
        @(negedge ap_clk);
        check("bp_nobubble_valid", 32'(bus.rsp_valid), 32'd1);
        check("bp_rr_skip_ready", 32'(bus.req_ready), 32'h4);
        @(negedge ap_clk);
        check("bp_nobubble_valid", 32'(bus.rsp_valid), 32'd1);
        check("bp_wrap_ready", 32'(bus.req_ready), 32'h2);
        @(posedge ap_clk);
        #1;
        bus.rsp_ready = 1'b0;
        @(negedge ap_clk);
        check("held_busy_cnt", 32'(bus.busy_cnt), 32'd7);
        check("held_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("held_rsp_id", 32'(bus.rsp_id), 32'd1);

        // Mid-operation reset pulse between edges discards the held response.
        #2;
        ap_rst_n = 1'b0;
        #1;
        check("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("midrst_rsp_id", 32'(bus.rsp_id), 32'd0);
        check("midrst_rsp_data", 32'(bus.rsp_data), 32'd0);
        check("midrst_busy_cnt", 32'(bus.busy_cnt), 32'd0);
        check("midrst_req_ready", 32'(bus.req_ready), 32'd0);
        if (sb.size() > 0) sb.delete(sb.size() - 1);
        #1;
        ap_rst_n = 1'b1;
        @(posedge ap_clk);
        #1;
        bus.rsp_ready = 1'b1;

        // Round-robin rotation, then requester 1 runs dry.
        @(negedge ap_clk);
        for (int i = 0; i < 11; i++) push_req(t_id[i], t_a[i], t_b[i], t_p[i]);
        @(negedge ap_clk);
        for (int i = 0; i < 11; i++) begin
            @(negedge ap_clk);
            check("rr_throughput_valid", 32'(bus.rsp_valid), 32'd1);
        end
        check("rr_busy_cnt", 32'(bus.busy_cnt), 32'd11);
        wait_drain(20, "rr_drain");

        // Counter saturation.
        @(negedge ap_clk);
        for (int i = 0; i < 65540; i++) push_req(0, 1, 1, 16'h0001);
        wait_drain(70000, "sat_drain");
        check("sat_busy_cnt", 32'(bus.busy_cnt), 32'hFFFF);
        @(negedge ap_clk);
        push_req(1, 2, 3, 16'h0006);
        wait_drain(20, "sat_hold_drain");
        check("sat_busy_cnt_held", 32'(bus.busy_cnt), 32'hFFFF);

        repeat (2) @(negedge ap_clk);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
